cp0_regs: RTL and testbench
===========================

# cp0_regs

Coprocessor-0 register file for the MIPS core. It sits directly downstream of the exception-type encoder and consumes its 32-bit `exception_type` at the memory/commit stage. It holds BadVAddr, Count, Compare, Status, Cause and EPC, serves MFC0/MTC0, and runs the Count/Compare timer. It drives the Status/Cause values the encoder uses for interrupt qualification, plus the flush/redirect target.

## Interface
- `EXC_VECTOR`, 32'hBFC0_0380: redirect target for every exception except ERET.
- `clk` in 1: core clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `we` in 1: MTC0 write enable.
- `waddr` in 5: MTC0 register number.
- `wdata` in 32: MTC0 data.
- `raddr` in 5: MFC0 register number.
- `rdata` out 32: MFC0 data; combinational from current register state.
- `exception_type` in 32: committed exception code.
- `pc` in 32: PC of the committing instruction.
- `in_delay_slot` in 1: the committing instruction is in a branch delay slot.
- `bad_addr` in 32: faulting data address.
- `int_i` in 6: hardware interrupt lines; level-sensitive.
- `status_o` out 32: current Status.
- `cause_o` out 32: current Cause.
- `epc_o` out 32: current EPC.
- `flush_o` out 1: high when `exception_type != EXC_NONE`; combinational.
- `new_pc_o` out 32: ERET gives `epc_o`; any other exception gives `EXC_VECTOR`; combinational.
- `timer_int_o` out 1: equals Cause.TI (bit 30).

## Operation
- `exception_type` codes (cp0_defines.vh):
  - NONE 0, INT 1, INST_ADD_ERR 2, DATA_ADD_ERR_L 3, DATA_ADD_ERR_S 4.
  - SYSCALL 5, BREAK 6, RI 7, OVF 8, ERET 9.
  - Any other value is treated as NONE.
- ExcCode mapping: INT→0x00, INST_ADD_ERR→0x04, DATA_ADD_ERR_L→0x04, DATA_ADD_ERR_S→0x05, SYSCALL→0x08, BREAK→0x09, RI→0x0a, OVF→0x0c.
- Register numbers: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Any other number reads 0; writes to it are ignored.
- Status fields:
  - Writable: IM[15:8], EXL[1], IE[0].
  - BEV[22] reads 1 always.
  - All other bits read 0.
- Cause fields:
  - BD[31]: hardware-written only.
  - TI[30]: hardware-written only.
  - IP[15:10]: sampled every cycle from `{int_i[5] | TI, int_i[4:0]}`.
  - IP[9:8]: MTC0-writable.
  - ExcCode[6:2]: hardware-written only.
  - Other bits read 0.
- BadVAddr: read-only to software.
- EPC, Count, Compare: full 32-bit MTC0-writable.
- Exception commit (type other than NONE or ERET), on the edge:
  - If Status.EXL is 0: EPC ← `in_delay_slot ? pc-4 : pc` and Cause.BD ← `in_delay_slot`. If EXL is already 1, EPC and BD are unchanged.
  - Status.EXL ← 1.
  - Cause.ExcCode ← mapped code.
  - INST_ADD_ERR: BadVAddr ← `pc`.
  - DATA_ADD_ERR_L/S: BadVAddr ← `bad_addr`.
- ERET commit: Status.EXL ← 0; no other state changes.
- Priority: when `exception_type != NONE`, `we` is ignored entirely in that cycle.
- Timer:
  - A 1-bit `tick` flop toggles every cycle; Count increments (mod 2^32) on cycles where `tick` is 1.
  - MTC0 to Count loads `wdata` and suppresses that cycle's increment; `tick` keeps toggling.
  - TI is set on the edge after Count == Compare. Set has priority over hold.
  - TI is cleared only by an MTC0 to Compare. If that write also makes Count == Compare, TI stays clear this edge and sets on the next edge if equality holds.
- Count wraps 0xFFFF_FFFF→0 silently.

## Timing
- Reset values:
  - Status 0x0040_0000; Cause, EPC, BadVAddr, Count, Compare all 0.
  - `tick` 0; `timer_int_o` 0.
  - `flush_o` 0 and `new_pc_o` = `EXC_VECTOR` while inputs are NONE.
- MTC0 writes are visible on `rdata` and `*_o` the cycle after the write edge. There is no write-to-read bypass.
- Exception and ERET updates are visible the cycle after commit. `flush_o` and `new_pc_o` respond in the same cycle as `exception_type`.
- Cause.IP lags `int_i` by one cycle.
- First Count increment lands on the 2nd rising edge after reset release.
- Reset asserted mid-operation returns every register to its reset value immediately, without waiting for a clock edge.

## Test plan
- Reset: release reset, then read Status and Count. Expect Status = 0x0040_0000. Expect Count = 0, then 1 after two edges, then 2 after four edges.
- SYSCALL outside a delay slot: `pc`=0x8000_1000, `in_delay_slot`=0. Same cycle: `flush_o`=1, `new_pc_o`=0xBFC0_0380. Next cycle: EPC=0x8000_1000, ExcCode=0x08, BD=0, Status bit 1 = 1.
- Exceptions in a delay slot, then nested:
  - DATA_ADD_ERR_S with `pc`=0x8000_2004, slot=1, `bad_addr`=0x0000_0003 → EPC=0x8000_2000, BD=1, ExcCode=0x05, BadVAddr=0x3.
  - A second OVF with `pc`=0x8000_3000 (EXL still 1) → EPC stays 0x8000_2000, ExcCode=0x0c.
- ERET: with EPC=0x8000_2000, drive ERET → `new_pc_o`=0x8000_2000, `flush_o`=1; EXL=0 next cycle.
- Timer:
  - MTC0 Count=10, then Compare=14 → TI=1 once Count reaches 14, and Cause bit 15 = 1 on the following cycle.
  - MTC0 Compare=100 → TI=0 next cycle.
- MTC0/exception collision: `we`=1 writing Status=0xFFFF_FFFF in the same cycle as RI → Status = 0x0040_0002 (EXL only), ExcCode=0x0a.

Source files
------------

// File: rtl/cp0_regs.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Serves MFC0/MTC0, commits exceptions/ERET and runs the Count/Compare timer.
module cp0_regs #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [31:0] exception_type,
    input  logic [31:0] pc,
    input  logic        in_delay_slot,
    input  logic [31:0] bad_addr,
    input  logic [5:0]  int_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        timer_int_o
);

    localparam logic [31:0] EXC_INT            = 32'd1;
    localparam logic [31:0] EXC_INST_ADD_ERR   = 32'd2;
    localparam logic [31:0] EXC_DATA_ADD_ERR_L = 32'd3;
    localparam logic [31:0] EXC_DATA_ADD_ERR_S = 32'd4;
    localparam logic [31:0] EXC_SYSCALL        = 32'd5;
    localparam logic [31:0] EXC_BREAK          = 32'd6;
    localparam logic [31:0] EXC_RI             = 32'd7;
    localparam logic [31:0] EXC_OVF            = 32'd8;
    localparam logic [31:0] EXC_ERET           = 32'd9;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [31:0] r_epc;
    logic        r_tick;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic        r_ti;
    logic [5:0]  r_ip_hw;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;

    logic        w_exc_valid;
    logic        w_eret;
    logic        w_exc_take;
    logic        w_wr;
    logic [4:0]  w_exccode;

    // Decode the committed exception; codes outside 1..9 behave as NONE.
    always_comb begin
        w_exc_valid = (exception_type >= EXC_INT) && (exception_type <= EXC_ERET);
        w_eret      = (exception_type == EXC_ERET);
        w_exc_take  = w_exc_valid && !w_eret;
        w_wr        = we && !w_exc_valid;
        case (exception_type)
            EXC_INST_ADD_ERR:   w_exccode = 5'h04;
            EXC_DATA_ADD_ERR_L: w_exccode = 5'h04;
            EXC_DATA_ADD_ERR_S: w_exccode = 5'h05;
            EXC_SYSCALL:        w_exccode = 5'h08;
            EXC_BREAK:          w_exccode = 5'h09;
            EXC_RI:             w_exccode = 5'h0a;
            EXC_OVF:            w_exccode = 5'h0c;
            default:            w_exccode = 5'h00;
        endcase
    end

    // Timer: Count advances on alternate cycles, TI latches on Count==Compare.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tick    <= 1'b0;
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
            if (w_wr && waddr == REG_COUNT) begin
                r_count <= wdata;
            end else if (r_tick) begin
                r_count <= r_count + 32'd1;
            end
            if (w_wr && waddr == REG_COMPARE) begin
                r_compare <= wdata;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti <= 1'b1;
            end
        end
    end

    // Status: EXL set on exception, cleared on ERET; MTC0 owns IM/EXL/IE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_im  <= 8'd0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
        end else if (w_exc_take) begin
            r_exl <= 1'b1;
        end else if (w_eret) begin
            r_exl <= 1'b0;
        end else if (w_wr && waddr == REG_STATUS) begin
            r_im  <= wdata[15:8];
            r_exl <= wdata[1];
            r_ie  <= wdata[0];
        end
    end

    // Cause: IP[15:10] resampled every cycle; BD/ExcCode on exception; IP[9:8] by MTC0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ip_hw   <= 6'd0;
            r_ip_sw   <= 2'd0;
            r_bd      <= 1'b0;
            r_exccode <= 5'd0;
        end else begin
            r_ip_hw <= {int_i[5] | r_ti, int_i[4:0]};
            if (w_exc_take) begin
                r_exccode <= w_exccode;
                if (!r_exl) begin
                    r_bd <= in_delay_slot;
                end
            end else if (w_wr && waddr == REG_CAUSE) begin
                r_ip_sw <= wdata[9:8];
            end
        end
    end

    // EPC captures the restart PC only for the outermost exception; BadVAddr on address errors.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_epc      <= 32'd0;
            r_badvaddr <= 32'd0;
        end else begin
            if (w_exc_take) begin
                if (!r_exl) begin
                    r_epc <= in_delay_slot ? (pc - 32'd4) : pc;
                end
                if (exception_type == EXC_INST_ADD_ERR) begin
                    r_badvaddr <= pc;
                end else if (exception_type == EXC_DATA_ADD_ERR_L ||
                             exception_type == EXC_DATA_ADD_ERR_S) begin
                    r_badvaddr <= bad_addr;
                end
            end else if (w_wr && waddr == REG_EPC) begin
                r_epc <= wdata;
            end
        end
    end

    // Register views, MFC0 read mux and redirect outputs.
    always_comb begin
        status_o    = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
        cause_o     = {r_bd, r_ti, 14'd0, r_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};
        epc_o       = r_epc;
        timer_int_o = r_ti;
        flush_o     = w_exc_valid;
        new_pc_o    = w_eret ? r_epc : EXC_VECTOR;
        case (raddr)
            REG_BADVADDR: rdata = r_badvaddr;
            REG_COUNT:    rdata = r_count;
            REG_COMPARE:  rdata = r_compare;
            REG_STATUS:   rdata = status_o;
            REG_CAUSE:    rdata = cause_o;
            REG_EPC:      rdata = r_epc;
            default:      rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Scoreboard bench for cp0_regs: expectations are queued with the stimulus
// and popped/compared at the sample point that follows.
module tb_cp0_regs;

    localparam int K_RD  = 0;
    localparam int K_FL  = 1;
    localparam int K_NPC = 2;
    localparam int K_TI  = 3;
    localparam int K_ST  = 4;
    localparam int K_CA  = 5;
    localparam int K_EPC = 6;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    typedef struct {
        string       tag;
        int          kind;
        logic [4:0]  addr;
        logic [31:0] mask;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic [4:0]  raddr = 5'd0;
    logic [31:0] rdata;
    logic [31:0] exception_type = 32'd0;
    logic [31:0] pc = 32'd0;
    logic        in_delay_slot = 1'b0;
    logic [31:0] bad_addr = 32'd0;
    logic [5:0]  int_i = 6'd0;
    logic [31:0] status_o, cause_o, epc_o, new_pc_o;
    logic        flush_o, timer_int_o;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    cp0_regs #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .resetn(resetn), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .exception_type(exception_type), .pc(pc),
        .in_delay_slot(in_delay_slot), .bad_addr(bad_addr), .int_i(int_i),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .flush_o(flush_o),
        .new_pc_o(new_pc_o), .timer_int_o(timer_int_o)
    );

    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input int kind, input logic [4:0] a,
                        input logic [31:0] m, input logic [31:0] e);
        exp_t x;
        x.tag = tag; x.kind = kind; x.addr = a; x.mask = m; x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        logic [31:0] got;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.kind)
                K_RD:    begin raddr = x.addr; #1; got = rdata; end
                K_FL:    got = {31'd0, flush_o};
                K_NPC:   got = new_pc_o;
                K_TI:    got = {31'd0, timer_int_o};
                K_ST:    got = status_o;
                K_CA:    got = cause_o;
                default: got = epc_o;
            endcase
            check_val(x.tag, got & x.mask, x.exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1 we = 1'b0;
        @(negedge clk);
    endtask

    // Drives one committing exception; same-cycle expectations already queued are checked first.
    task automatic commit(input logic [31:0] t, input logic [31:0] p, input logic s,
                          input logic [31:0] b);
        exception_type = t; pc = p; in_delay_slot = s; bad_addr = b;
        #2 drain();
        @(posedge clk);
        #1 exception_type = 32'd0; we = 1'b0; in_delay_slot = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        push("rst_status", K_ST, 0, 32'hFFFF_FFFF, 32'h0040_0000);
        push("rst_cause", K_CA, 0, 32'hFFFF_FFFF, 32'h0);
        push("rst_epc", K_EPC, 0, 32'hFFFF_FFFF, 32'h0);
        push("rst_ti", K_TI, 0, 32'h1, 32'h0);
        push("rst_flush", K_FL, 0, 32'h1, 32'h0);
        push("rst_npc", K_NPC, 0, 32'hFFFF_FFFF, VEC);
        push("rst_cnt", K_RD, 5'd9, 32'hFFFF_FFFF, 32'd0);
        drain();
        resetn = 1'b1;
        push("rel_status", K_RD, 5'd12, 32'hFFFF_FFFF, 32'h0040_0000);
        push("rel_cnt0", K_RD, 5'd9, 32'hFFFF_FFFF, 32'd0);
        drain();
        step(1);
        push("cnt_edge1", K_RD, 5'd9, 32'hFFFF_FFFF, 32'd0);
        push("ti_eq_rst", K_TI, 0, 32'h1, 32'h1);
        drain();
        step(1);
        push("cnt_edge2", K_RD, 5'd9, 32'hFFFF_FFFF, 32'd1);
        drain();
        step(2);
        push("cnt_edge4", K_RD, 5'd9, 32'hFFFF_FFFF, 32'd2);
        drain();

        // SYSCALL outside a delay slot
        push("sys_flush", K_FL, 0, 32'h1, 32'h1);
        push("sys_npc", K_NPC, 0, 32'hFFFF_FFFF, VEC);
        commit(32'd5, 32'h8000_1000, 1'b0, 32'h0);
        push("sys_epc", K_RD, 5'd14, 32'hFFFF_FFFF, 32'h8000_1000);
        push("sys_cause", K_CA, 0, 32'h8000_007C, 32'h0000_0020);
        push("sys_exl", K_ST, 0, 32'h2, 32'h2);
        drain();

        push("eret1_npc", K_NPC, 0, 32'hFFFF_FFFF, 32'h8000_1000);
        commit(32'd9, 32'h0, 1'b0, 32'h0);
        push("eret1_exl", K_ST, 0, 32'hFFFF_FFFF, 32'h0040_0000);
        drain();

        // Delay-slot store address error, then nested overflow
        commit(32'd4, 32'h8000_2004, 1'b1, 32'h0000_0003);
        push("ds_epc", K_EPC, 0, 32'hFFFF_FFFF, 32'h8000_2000);
        push("ds_cause", K_CA, 0, 32'h8000_007C, 32'h8000_0014);
        push("ds_bva", K_RD, 5'd8, 32'hFFFF_FFFF, 32'h0000_0003);
        drain();
        commit(32'd8, 32'h8000_3000, 1'b0, 32'h0);
        push("nest_epc", K_EPC, 0, 32'hFFFF_FFFF, 32'h8000_2000);
        push("nest_cause", K_CA, 0, 32'h8000_007C, 32'h8000_0030);
        push("nest_bva", K_RD, 5'd8, 32'hFFFF_FFFF, 32'h0000_0003);
        drain();

        // Unknown code behaves as NONE
        push("unk_flush", K_FL, 0, 32'h1, 32'h0);
        push("unk_npc", K_NPC, 0, 32'hFFFF_FFFF, VEC);
        commit(32'd12, 32'h8000_7000, 1'b0, 32'h0);
        push("unk_epc", K_EPC, 0, 32'hFFFF_FFFF, 32'h8000_2000);
        drain();

        push("eret_npc", K_NPC, 0, 32'hFFFF_FFFF, 32'h8000_2000);
        push("eret_flush", K_FL, 0, 32'h1, 32'h1);
        commit(32'd9, 32'h0, 1'b0, 32'h0);
        push("eret_exl", K_ST, 0, 32'h2, 32'h0);
        push("eret_epc", K_EPC, 0, 32'hFFFF_FFFF, 32'h8000_2000);
        drain();

        // Timer
        mtc0(5'd9, 32'd10);
        mtc0(5'd11, 32'd14);
        push("ti_clr", K_TI, 0, 32'h1, 32'h0);
        drain();
        n = 0;
        while (!timer_int_o && n < 40) begin
            step(1);
            n++;
        end
        check_val("ti_wait", {31'd0, timer_int_o}, 32'd1);
        push("ti_cnt", K_RD, 5'd9, 32'hFFFF_FFFF, 32'd14);
        drain();
        step(1);
        push("ti_ip7", K_CA, 0, 32'h0000_8000, 32'h0000_8000);
        drain();
        step(3);
        push("ti_hold", K_TI, 0, 32'h1, 32'h1);
        drain();
        mtc0(5'd11, 32'd100);
        push("ti_clr100", K_TI, 0, 32'h1, 32'h0);
        push("cmp_rd", K_RD, 5'd11, 32'hFFFF_FFFF, 32'd100);
        drain();

        // Interrupt lines lag by one cycle
        int_i = 6'b000101;
        #2;
        push("ip_lag", K_CA, 0, 32'h0000_FC00, 32'h0000_8000);
        drain();
        step(1);
        push("ip_sample", K_CA, 0, 32'h0000_FC00, 32'h0000_1400);
        drain();
        int_i = 6'd0;

        // MTC0 colliding with RI
        we = 1'b1; waddr = 5'd12; wdata = 32'hFFFF_FFFF;
        push("col_flush", K_FL, 0, 32'h1, 32'h1);
        commit(32'd7, 32'h8000_4000, 1'b0, 32'h0);
        push("col_status", K_ST, 0, 32'hFFFF_FFFF, 32'h0040_0002);
        push("col_cause", K_CA, 0, 32'h0000_007C, 32'h0000_0028);
        push("col_epc", K_EPC, 0, 32'hFFFF_FFFF, 32'h8000_4000);
        drain();

        commit(32'd2, 32'h8000_5001, 1'b0, 32'h0);
        push("iae_bva", K_RD, 5'd8, 32'hFFFF_FFFF, 32'h8000_5001);
        push("iae_cause", K_CA, 0, 32'h0000_007C, 32'h0000_0010);
        push("iae_epc", K_EPC, 0, 32'hFFFF_FFFF, 32'h8000_4000);
        drain();

        // Software writes and field masks
        mtc0(5'd12, 32'hFFFF_FFFF);
        push("st_wr", K_RD, 5'd12, 32'hFFFF_FFFF, 32'h0040_FF03);
        drain();
        mtc0(5'd13, 32'hFFFF_FFFF);
        push("ca_wr", K_RD, 5'd13, 32'h3FFF_03FF, 32'h0000_0310);
        drain();
        mtc0(5'd8, 32'hDEAD_BEEF);
        push("bva_ro", K_RD, 5'd8, 32'hFFFF_FFFF, 32'h8000_5001);
        drain();
        mtc0(5'd5, 32'h1234_5678);
        push("unmapped", K_RD, 5'd5, 32'hFFFF_FFFF, 32'h0);
        drain();
        mtc0(5'd14, 32'hCAFE_F00C);
        push("epc_wr", K_EPC, 0, 32'hFFFF_FFFF, 32'hCAFE_F00C);
        drain();

        // Count wrap
        mtc0(5'd9, 32'hFFFF_FFFF);
        raddr = 5'd9;
        #1;
        n = 0;
        while (rdata == 32'hFFFF_FFFF && n < 4) begin
            step(1);
            n++;
        end
        check_val("cnt_wrap", rdata, 32'd0);

        // Asynchronous reset mid-operation
        #3 resetn = 1'b0;
        #1;
        push("arst_status", K_ST, 0, 32'hFFFF_FFFF, 32'h0040_0000);
        push("arst_cause", K_CA, 0, 32'hFFFF_FFFF, 32'h0);
        push("arst_epc", K_EPC, 0, 32'hFFFF_FFFF, 32'h0);
        push("arst_ti", K_TI, 0, 32'h1, 32'h0);
        push("arst_cnt", K_RD, 5'd9, 32'hFFFF_FFFF, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
